// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit serializer. Accepts one word per valid/ready
//               handshake and shifts it out as start bit, DATA_BITS data bits
//               LSB-first, optional parity bit and STOP_BITS stop bits, with
//               every bit boundary aligned to the external baud_tick pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int                 CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic               HAS_PAR  = (PARITY_EN != 0);
  localparam logic               ODD_PAR  = (PARITY_ODD != 0);
  localparam logic               TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 parity_bit;
  logic                 accept;

  // Ready only while idle, so a word offered in the tx_done cycle is taken.
  assign tx_ready = (state == ST_IDLE);
  assign accept   = tx_valid && tx_ready;

  // Frame sequencer: every state exit past IDLE is gated by baud_tick so each
  // bit, including start, lasts exactly one tick interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          // A tick coincident with acceptance is deliberately not used here;
          // SYNC waits for the next one to align the start bit to the grid.
          if (accept) begin
            shreg      <= tx_data;
            parity_bit <= (^tx_data) ^ ODD_PAR;
            busy       <= 1'b1;
            state      <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            tx      <= shreg[0];
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt != LAST_BIT) begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (HAS_PAR) begin
              tx    <= parity_bit;
              state <= ST_PARITY;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (baud_tick) begin
            if (TWO_STOP && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              tx_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for uart_tx_serializer. Four instances
//               cover default, even parity, odd parity and two stop bits.
//               Expected frames come from a bit-list model of the UART frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  localparam int TICK_DIV = 4;
  localparam int NINST    = 4;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] tx_data  [NINST];
  logic       tx_valid [NINST];
  logic       tx_w     [NINST];
  logic       busy_w   [NINST];
  logic       done_w   [NINST];
  logic       ready_w  [NINST];

  int checks;
  int errors;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running baud tick, one cycle high every TICK_DIV clocks.
  initial begin
    int div;
    div       = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      div       = (div == TICK_DIV - 1) ? 0 : div + 1;
      baud_tick = (div == 0);
    end
  end

  // Instance configuration table.
  function automatic int cfg_pen(input int idx);
    return (idx == 1 || idx == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_podd(input int idx);
    return (idx == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_stop(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  // Reference frame as a list of line levels, one per bit period, followed by
  // the idle-high level of the tx_done cycle. len is the number of bit periods.
  task automatic model(input int idx, input logic [7:0] d, output logic [15:0] e, output int len);
    int ones;
    e    = '1;
    e[0] = 1'b0;
    for (int i = 0; i < 8; i++) e[1+i] = d[i];
    ones = $countones(d);
    if (cfg_pen(idx) == 1) begin
      if (cfg_podd(idx) == 1) e[9] = ((ones % 2) == 0);
      else                    e[9] = ((ones % 2) == 1);
    end
    len = 1 + 8 + cfg_pen(idx) + cfg_stop(idx);
  endtask

  function automatic logic [15:0] mask_of(input int len);
    logic [31:0] t;
    t = (32'd1 << (len + 1)) - 32'd1;
    return t[15:0];
  endfunction

  // Offers a word and returns one time unit after the accepting clock edge.
  task automatic do_accept(input int idx, input logic [7:0] d, input bit on_tick, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (ready_w[idx] === 1'b1 && (!on_tick || baud_tick === 1'b1)) begin
        tx_data[idx]  = d;
        tx_valid[idx] = 1'b1;
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Observes one frame starting right after the accept edge. Records the line
  // level at the start of each tick period, counts level changes inside a
  // period, SYNC cycles, and handshake/busy misbehaviour until tx_done.
  task automatic collect(input int idx, input int stop_ticks, output logic [15:0] bits,
                         output int nper, output int pre, output int glitch, output int bad,
                         output bit done_seen, output bit rdy_at_done, output bit busy_at_done,
                         output bit done_on_tick);
    int ticks;
    bit t;
    bits = '1; nper = 0; pre = 0; glitch = 0; bad = 0; ticks = 0;
    done_seen = 0; rdy_at_done = 0; busy_at_done = 1; done_on_tick = 0;
    if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b1 || ready_w[idx] !== 1'b0 || done_w[idx] !== 1'b0) bad++;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      t = baud_tick;
      @(posedge clk); #1;
      if (t) begin
        ticks++;
        if (ticks <= 16) bits[ticks-1] = tx_w[idx];
      end else if (ticks == 0) begin
        pre++;
        if (tx_w[idx] !== 1'b1) glitch++;
      end else if (ticks <= 16 && tx_w[idx] !== bits[ticks-1]) begin
        glitch++;
      end
      nper = ticks;
      if (done_w[idx] === 1'b1) begin
        done_seen    = 1;
        rdy_at_done  = ready_w[idx];
        busy_at_done = busy_w[idx];
        done_on_tick = t;
        nper         = ticks - 1;
        break;
      end
      if (busy_w[idx] !== 1'b1 || ready_w[idx] !== 1'b0) bad++;
      if (stop_ticks != 0 && ticks >= stop_ticks) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NINST; i++) begin
      checks++; if (tx_w[i] !== 1'b1) begin errors++; $display("FAIL reset_tx[%0d] got %b want 1", i, tx_w[i]); end
      checks++; if (busy_w[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy_w[i]); end
      checks++; if (done_w[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b want 0", i, done_w[i]); end
      checks++; if (ready_w[i] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got %b want 1", i, ready_w[i]); end
    end
  endtask

  task automatic test_basic_a5;
    logic [15:0] b, e, m, lit;
    int np, pre, gl, bad, len;
    bit ds, rd, bd, dt, ok;
    lit = 16'h074A;
    do_accept(0, 8'hA5, 1'b0, ok);
    tx_valid[0] = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL a5_accept got %b want 1", ok); end
    collect(0, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
    model(0, 8'hA5, e, len);
    m = mask_of(len);
    checks++; if (ds !== 1'b1) begin errors++; $display("FAIL a5_done got %b want 1", ds); end
    checks++; if (np !== 10) begin errors++; $display("FAIL a5_periods got %0d want 10", np); end
    checks++; if ((b & m) !== (e & m)) begin errors++; $display("FAIL a5_bits got %h want %h", b & m, e & m); end
    checks++; if ((b & 16'h07FF) !== lit) begin errors++; $display("FAIL a5_literal got %h want %h", b & 16'h07FF, lit); end
    checks++; if (gl !== 0) begin errors++; $display("FAIL a5_bit_width got %0d want 0", gl); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL a5_ready_busy got %0d want 0", bad); end
    checks++; if (dt !== 1'b1) begin errors++; $display("FAIL a5_done_on_tick got %b want 1", dt); end
    checks++; if (rd !== 1'b1 || bd !== 1'b0) begin errors++; $display("FAIL a5_done_state got rdy=%b busy=%b want rdy=1 busy=0", rd, bd); end
    @(posedge clk); #1;
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL a5_done_width got %b want 0", done_w[0]); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] b, e, m;
    int np, pre, gl, bad, len;
    bit ds, rd, bd, dt, ok;
    do_accept(0, 8'h3C, 1'b0, ok);
    tx_data[0] = 8'hFF;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", ok); end
    collect(0, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
    model(0, 8'h3C, e, len);
    m = mask_of(len);
    checks++; if ((b & m) !== (e & m) || np !== len) begin errors++; $display("FAIL b2b_frame1 got %h/%0d want %h/%0d", b & m, np, e & m, len); end
    checks++; if (ds !== 1'b1 || rd !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done got done=%b rdy=%b want 1 1", ds, rd); end
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    tx_data[0]  = 8'h5A;
    checks++; if (busy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got busy=%b done=%b want 1 0", busy_w[0], done_w[0]); end
    collect(0, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
    model(0, 8'hFF, e, len);
    m = mask_of(len);
    checks++; if ((b & m) !== (e & m) || np !== len || ds !== 1'b1) begin errors++; $display("FAIL b2b_frame2 got %h/%0d want %h/%0d", b & m, np, e & m, len); end
    checks++; if (pre !== TICK_DIV - 2) begin errors++; $display("FAIL b2b_gap got %0d want %0d", pre, TICK_DIV - 2); end
    checks++; if (gl !== 0 || bad !== 0) begin errors++; $display("FAIL b2b_integrity got gl=%0d bad=%0d want 0 0", gl, bad); end
  endtask

  task automatic test_parity;
    logic [15:0] b, e, m;
    int np, pre, gl, bad, len;
    bit ds, rd, bd, dt, ok;
    for (int idx = 1; idx <= 2; idx++) begin
      do_accept(idx, 8'h07, 1'b0, ok);
      tx_valid[idx] = 1'b0;
      collect(idx, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
      model(idx, 8'h07, e, len);
      m = mask_of(len);
      checks++; if (np !== 11 || ds !== 1'b1) begin errors++; $display("FAIL parity_len[%0d] got %0d want 11", idx, np); end
      checks++; if (b[9] !== ((idx == 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL parity_bit[%0d] got %b want %b", idx, b[9], (idx == 1)); end
      checks++; if ((b & m) !== (e & m) || gl !== 0 || bad !== 0) begin errors++; $display("FAIL parity_frame[%0d] got %h want %h", idx, b & m, e & m); end
    end
  endtask

  task automatic test_two_stop;
    logic [15:0] b, e, m;
    int np, pre, gl, bad, len;
    bit ds, rd, bd, dt, ok;
    do_accept(3, 8'h00, 1'b0, ok);
    tx_valid[3] = 1'b0;
    collect(3, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
    model(3, 8'h00, e, len);
    m = mask_of(len);
    checks++; if (np !== 11 || ds !== 1'b1) begin errors++; $display("FAIL stop2_len got %0d want 11", np); end
    checks++; if ((b & m) !== (e & m) || gl !== 0) begin errors++; $display("FAIL stop2_bits got %h want %h", b & m, e & m); end
    checks++; if (rd !== 1'b1 || bd !== 1'b0 || bad !== 0) begin errors++; $display("FAIL stop2_end got rdy=%b busy=%b bad=%0d want 1 0 0", rd, bd, bad); end
  endtask

  task automatic test_robustness;
    logic [15:0] b, e, m;
    logic [7:0]  d;
    int np, pre, gl, bad, len, extra;
    bit ds, rd, bd, dt, ok;
    d = 8'($urandom);
    do_accept(0, d, 1'b0, ok);
    fork
      collect(0, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk); #2;
          tx_data[0]  = 8'($urandom);
          tx_valid[0] = 1'($urandom_range(0, 1));
        end
        tx_valid[0] = 1'b0;
      end
    join
    model(0, d, e, len);
    m = mask_of(len);
    checks++; if ((b & m) !== (e & m) || np !== len || ds !== 1'b1) begin errors++; $display("FAIL robust_frame got %h/%0d want %h/%0d", b & m, np, e & m, len); end
    checks++; if (bad !== 0 || gl !== 0) begin errors++; $display("FAIL robust_no_accept got bad=%0d gl=%0d want 0 0", bad, gl); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL robust_idle_after got %0d want 0", extra); end
    d = 8'($urandom);
    do_accept(0, d, 1'b1, ok);
    tx_valid[0] = 1'b0;
    collect(0, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
    model(0, d, e, len);
    m = mask_of(len);
    checks++; if (pre !== TICK_DIV - 1) begin errors++; $display("FAIL tick_on_accept_wait got %0d want %0d", pre, TICK_DIV - 1); end
    checks++; if ((b & m) !== (e & m) || np !== len || gl !== 0) begin errors++; $display("FAIL tick_on_accept_frame got %h want %h", b & m, e & m); end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] b, e, m;
    logic [7:0]  d;
    int np, pre, gl, bad, len, cnt;
    bit ds, rd, bd, dt, ok;
    do_accept(0, 8'($urandom), 1'b0, ok);
    tx_valid[0] = 1'b0;
    collect(0, 5, b, np, pre, gl, bad, ds, rd, bd, dt);
    checks++; if (np !== 5 || ds !== 1'b0) begin errors++; $display("FAIL rst_reach_bit3 got %0d want 5", np); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
      errors++; $display("FAIL rst_immediate got tx=%b busy=%b rdy=%b want 1 0 1", tx_w[0], busy_w[0], ready_w[0]);
    end
    cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (done_w[0] !== 1'b0) cnt++; end
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", cnt); end
    d = 8'($urandom);
    do_accept(0, d, 1'b0, ok);
    tx_valid[0] = 1'b0;
    collect(0, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
    model(0, d, e, len);
    m = mask_of(len);
    checks++; if ((b & m) !== (e & m) || np !== len || ds !== 1'b1 || gl !== 0 || bad !== 0) begin
      errors++; $display("FAIL rst_next_frame got %h/%0d want %h/%0d", b & m, np, e & m, len);
    end
  endtask

  task automatic test_random;
    logic [15:0] b, e, m;
    logic [7:0]  d;
    int np, pre, gl, bad, len, idx;
    bit ds, rd, bd, dt, ok;
    for (int n = 0; n < 12; n++) begin
      idx = $urandom_range(0, NINST - 1);
      d   = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      do_accept(idx, d, 1'($urandom_range(0, 1)), ok);
      tx_valid[idx] = 1'b0;
      tx_data[idx]  = 8'($urandom);
      collect(idx, 0, b, np, pre, gl, bad, ds, rd, bd, dt);
      model(idx, d, e, len);
      m = mask_of(len);
      checks++; if ((b & m) !== (e & m) || np !== len || ds !== 1'b1) begin
        errors++; $display("FAIL random[%0d] inst=%0d data=%h got %h/%0d want %h/%0d", n, idx, d, b & m, np, e & m, len);
      end
      checks++; if (gl !== 0 || bad !== 0 || pre > TICK_DIV - 1 || dt !== 1'b1) begin
        errors++; $display("FAIL random_timing[%0d] got gl=%0d bad=%0d pre=%0d tick=%b want 0 0 <=%0d 1", n, gl, bad, pre, dt, TICK_DIV - 1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic_a5;
    test_back_to_back;
    test_parity;
    test_two_stop;
    test_robustness;
    test_reset_midframe;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
